// File: rtl/axil_mem.sv
// axil_mem: AXI4-Lite word memory with byte strobes, one outstanding txn per channel.
// Optional AXIL_MEM_STALL_EN adds LFSR-driven ready backpressure.
module axil_mem #(
  parameter int          WORDS = 256,
  parameter logic [31:0] INIT  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] AWADDR,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic        ARVALID,
  output logic        ARREADY,
  input  logic [31:0] ARADDR,
  output logic        RVALID,
  input  logic        RREADY,
  output logic [31:0] RDATA
);
  localparam int AW = $clog2(WORDS);
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [31:0] mem [WORDS] = '{default: INIT};
  logic rdy_en, aw_held, w_held, stall;
  logic [AW-1:0] aw_idx_q, wr_idx;
  logic [31:0] w_data_q, wr_data;
  logic [3:0] w_strb_q, wr_strb;
  logic aw_hs, w_hs, ar_hs, commit;
  logic unused;
  assign unused = ^{AWADDR[31:AW+2], AWADDR[1:0], ARADDR[31:AW+2], ARADDR[1:0]};
`ifdef AXIL_MEM_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif
  assign AWREADY = rdy_en && w_state == W_IDLE && !aw_held && !stall;
  assign WREADY  = rdy_en && w_state == W_IDLE && !w_held && !stall;
  assign ARREADY = rdy_en && r_state == R_IDLE && !stall;
  assign BVALID  = w_state == W_RESP;
  assign RVALID  = r_state == R_RESP;
  always_comb begin
    aw_hs   = AWVALID && AWREADY;
    w_hs    = WVALID && WREADY;
    ar_hs   = ARVALID && ARREADY;
    commit  = w_state == W_IDLE && (aw_held || aw_hs) && (w_held || w_hs);
    wr_idx  = aw_held ? aw_idx_q : AWADDR[AW+1:2];
    wr_data = w_held ? w_data_q : WDATA;
    wr_strb = w_held ? w_strb_q : WSTRB;
    w_next  = w_state == W_IDLE ? (commit ? W_RESP : W_IDLE) : (BREADY ? W_IDLE : W_RESP);
    r_next  = r_state == R_IDLE ? (ar_hs ? R_RESP : R_IDLE) : (RREADY ? R_IDLE : R_RESP);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state  <= W_IDLE;
      r_state  <= R_IDLE;
      rdy_en   <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      RDATA    <= '0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      rdy_en  <= 1'b1;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= AWADDR[AW+1:2];
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= WDATA;
          w_strb_q <= WSTRB;
        end
      end
      if (ar_hs) RDATA <= mem[ARADDR[AW+1:2]];
    end
  end
  // Array has no reset so its contents survive reset assertion.
  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++)
      if (commit && wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
  end
endmodule
